// File: rtl/sad_pkg.sv
// Shared definitions for the SAD minimum tracker: FSM state type,
// default SAD width / block size, and the candidate-count helper.
package sad_pkg;

  localparam int SAD_W = 32;
  localparam int WIN   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  // Number of block positions along one axis of the search frame.
  function automatic int num_pos(input int frame, input int win);
    return frame - win + 1;
  endfunction

endpackage

// File: rtl/sad_pos_counter.sv
// 2-D raster position counter (x fastest) with clear, advance and a flag
// marking the last candidate position.
module sad_pos_counter #(
  parameter int NX = 13,
  parameter int NY = 13,
  parameter int XW = 4,
  parameter int YW = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          adv_i,
  output logic [XW-1:0] pos_x_o,
  output logic [YW-1:0] pos_y_o,
  output logic          last_o
);
  import sad_pkg::*;

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;

  // Next position: clear has priority; x wraps at NX-1 and carries into y.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clr_i) begin
      x_d = '0;
      y_d = '0;
    end else if (adv_i) begin
      if (x_q == XW'(NX - 1)) begin
        x_d = '0;
        if (y_q == YW'(NY - 1)) y_d = '0;
        else                    y_d = y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  // Position registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign pos_x_o = x_q;
  assign pos_y_o = y_q;
  assign last_o  = (x_q == XW'(NX - 1)) && (y_q == YW'(NY - 1));

endmodule

// File: rtl/sad_min_tracker.sv
// Tracks the minimum SAD and its (x, y) over a raster scan of candidate
// block positions, pulsing Done when the scan completes.
// Optional feature macro: SAD_EARLY_EXIT_EN (a zero SAD ends the scan).
module sad_min_tracker #(
  parameter int FRAME_W = 16,
  parameter int FRAME_H = 16,
  parameter int WIN     = sad_pkg::WIN,
  parameter int SAD_W   = sad_pkg::SAD_W
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       Start,
  input  logic                       SADValid,
  input  logic [SAD_W-1:0]           SADIn,
  output logic                       Ready,
  output logic                       Busy,
  output logic                       Done,
  output logic [SAD_W-1:0]           MinSAD,
  output logic [$clog2(FRAME_W)-1:0] MinX,
  output logic [$clog2(FRAME_H)-1:0] MinY
);
  import sad_pkg::*;

  localparam int XW = $clog2(FRAME_W);
  localparam int YW = $clog2(FRAME_H);
  localparam int NX = num_pos(FRAME_W, WIN);
  localparam int NY = num_pos(FRAME_H, WIN);

  state_e           state_q, state_d;
  logic [SAD_W-1:0] min_sad_q, min_sad_d;
  logic [XW-1:0]    min_x_q, min_x_d;
  logic [YW-1:0]    min_y_q, min_y_d;
  logic             scan_q, done_q;
  logic             pos_clr, pos_adv, pos_last, zero_exit;
  logic [XW-1:0]    pos_x;
  logic [YW-1:0]    pos_y;

  sad_pos_counter #(
    .NX(NX),
    .NY(NY),
    .XW(XW),
    .YW(YW)
  ) u_pos (
    .clk_i  (Clk),
    .rst_ni (Reset),
    .clr_i  (pos_clr),
    .adv_i  (pos_adv),
    .pos_x_o(pos_x),
    .pos_y_o(pos_y),
    .last_o (pos_last)
  );

`ifdef SAD_EARLY_EXIT_EN
  assign zero_exit = (SADIn == '0);
`else
  assign zero_exit = 1'b0;
`endif

  // Next state and minimum update; strict compare keeps the earliest tie.
  always_comb begin
    state_d   = state_q;
    min_sad_d = min_sad_q;
    min_x_d   = min_x_q;
    min_y_d   = min_y_q;
    pos_clr   = 1'b0;
    pos_adv   = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d   = SCAN;
          pos_clr   = 1'b1;
          min_sad_d = '1;
          min_x_d   = '0;
          min_y_d   = '0;
        end
      end
      SCAN: begin
        if (SADValid) begin
          pos_adv = 1'b1;
          if (SADIn < min_sad_q) begin
            min_sad_d = SADIn;
            min_x_d   = pos_x;
            min_y_d   = pos_y;
          end
          if (pos_last || zero_exit) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, result and registered status outputs.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= IDLE;
      min_sad_q <= '1;
      min_x_q   <= '0;
      min_y_q   <= '0;
      scan_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      min_sad_q <= min_sad_d;
      min_x_q   <= min_x_d;
      min_y_q   <= min_y_d;
      scan_q    <= (state_d == SCAN);
      done_q    <= (state_d == DONE);
    end
  end

  assign Ready  = scan_q;
  assign Busy   = scan_q;
  assign Done   = done_q;
  assign MinSAD = min_sad_q;
  assign MinX   = min_x_q;
  assign MinY   = min_y_q;

endmodule

// File: tb/tb_sad_min_tracker.sv
// Randomized bench for sad_min_tracker (8x8 frame, 4x4 block, 25 candidates)
// with a scan-level reference model and per-cycle output comparison.
module tb_sad_min_tracker;

  localparam int FW = 8;
  localparam int FH = 8;
  localparam int W  = 4;
  localparam int SW = 32;
  localparam int NX = FW - W + 1;
  localparam int NC = NX * (FH - W + 1);
`ifdef SAD_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          sv = 1'b0;
  logic [SW-1:0] sin = '0;
  logic          ready, busy, done;
  logic [SW-1:0] min_sad;
  logic [2:0]    min_x, min_y;

  always #5 clk = ~clk;

  sad_min_tracker #(
    .FRAME_W(FW),
    .FRAME_H(FH),
    .WIN    (W),
    .SAD_W  (SW)
  ) dut (
    .Clk     (clk),
    .Reset   (rst_n),
    .Start   (start),
    .SADValid(sv),
    .SADIn   (sin),
    .Ready   (ready),
    .Busy    (busy),
    .Done    (done),
    .MinSAD  (min_sad),
    .MinX    (min_x),
    .MinY    (min_y)
  );

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 scanning, 2 reporting; minimum kept as
  // value plus raster index of the first occurrence.
  int            m_phase = 0;
  int            m_cnt = 0;
  int            m_idx = 0;
  logic [SW-1:0] m_min = '1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_cnt   <= 0;
      m_idx   <= 0;
      m_min   <= '1;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_phase <= 1;
          m_cnt   <= 0;
          m_idx   <= 0;
          m_min   <= '1;
        end
        1: if (sv) begin
          if (sin < m_min) begin
            m_min <= sin;
            m_idx <= m_cnt;
          end
          m_cnt <= m_cnt + 1;
          if (m_cnt + 1 == NC || (EARLY && sin == 0)) m_phase <= 2;
        end
        default: m_phase <= 0;
      endcase
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("ready",  ready,   m_phase == 1);
    chk("busy",   busy,    m_phase == 1);
    chk("done",   done,    m_phase == 2);
    chk("minsad", min_sad, m_min);
    chk("minx",   min_x,   m_idx % NX);
    chk("miny",   min_y,   m_idx / NX);
    if (done) done_cnt++;
  end

  logic [SW-1:0] vals [NC];

  task automatic fill(input logic [SW-1:0] v);
    for (int k = 0; k < NC; k++) vals[k] = v;
  endtask

  task automatic idle_noise();
    repeat (6) begin
      sv  = 1'($urandom_range(0, 1));
      sin = SW'($urandom_range(0, 3));
      @(posedge clk); #1;
    end
    sv = 1'b0;
  endtask

  task automatic run_scan(input bit stalls, input bit start_mid);
    int i;
    int cyc;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    i = 0;
    cyc = 0;
    while (m_phase == 1 && cyc < 400) begin
      sv    = stalls ? 1'($urandom_range(0, 1)) : 1'b1;
      start = start_mid && (cyc % 7 == 3);
      sin   = sv ? vals[i] : SW'($urandom);
      @(posedge clk); #1;
      if (sv) i++;
      cyc++;
    end
    sv = 1'b0;
    start = 1'b0;
    if (cyc >= 400) chk("scan_timeout", 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  int d0;

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_minsad", min_sad, 32'hFFFF_FFFF);
    chk("rst_ready",  ready, 1'b0);
    chk("rst_done",   done, 1'b0);
    rst_n = 1'b1;
    idle_noise();
    chk("idle_minsad", min_sad, 32'hFFFF_FFFF);

    // Single minimum at index 13 -> (3, 2).
    fill(32'd100); vals[13] = 32'd7;
    d0 = done_cnt;
    run_scan(1'b0, 1'b0);
    chk("full_done_pulses", done_cnt - d0, 1);
    chk("full_accepts", m_cnt, 25);
    chk("full_minsad", min_sad, 7);
    chk("full_minx", min_x, 3);
    chk("full_miny", min_y, 2);
    idle_noise();

    // Tie: earliest position (index 4) wins.
    fill(32'd50); vals[4] = 32'd5; vals[20] = 32'd5;
    run_scan(1'b0, 1'b0);
    chk("tie_minsad", min_sad, 5);
    chk("tie_minx", min_x, 4);
    chk("tie_miny", min_y, 0);

    // Stalls with Start pulses during the scan.
    fill(32'd100); vals[13] = 32'd7;
    d0 = done_cnt;
    run_scan(1'b1, 1'b1);
    chk("stall_done_pulses", done_cnt - d0, 1);
    chk("stall_accepts", m_cnt, 25);
    chk("stall_minsad", min_sad, 7);
    chk("stall_minx", min_x, 3);
    chk("stall_miny", min_y, 2);

    // Abort by reset after 10 accepts, then a fresh scan.
    for (int k = 0; k < NC; k++) vals[k] = SW'($urandom_range(1, 1000));
    d0 = done_cnt;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    sv = 1'b1;
    for (int k = 0; k < 10; k++) begin
      sin = vals[k];
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    sv = 1'b0;
    #1;
    chk("abort_ready", ready, 1'b0);
    chk("abort_minsad", min_sad, 32'hFFFF_FFFF);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt - d0, 0);
    fill(32'd200); vals[22] = 32'd9;
    run_scan(1'b1, 1'b0);
    chk("restart_minsad", min_sad, 9);
    chk("restart_minx", min_x, 2);
    chk("restart_miny", min_y, 4);

    // Zero at index 6 -> (1, 1); early exit only with the macro.
    fill(32'd100); vals[6] = 32'd0;
    d0 = done_cnt;
    run_scan(1'b0, 1'b0);
    chk("zero_accepts", m_cnt, EARLY ? 7 : 25);
    chk("zero_done_pulses", done_cnt - d0, 1);
    chk("zero_minsad", min_sad, 0);
    chk("zero_minx", min_x, 1);
    chk("zero_miny", min_y, 1);
    chk("zero_ready_after", ready, 1'b0);

    // Random scans: narrow range for frequent ties, wide range with zeros.
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < NC; k++)
        vals[k] = (r < 3) ? SW'($urandom_range(1, 20)) : SW'($urandom_range(0, 60));
      run_scan(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      idle_noise();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
